// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared state type, default 640x480@60 timing and field widths for the VGA receiver
package vga_rx_pkg;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;
  localparam int H_TOTAL_DEF     = 800;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int RGB_W   = 8;
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int XY_W    = 10;
endpackage

// File: rtl/vga_edge_counter.sv
// vga_edge_counter: sync leading-edge detect plus saturating counter with a length compare
// clk/rst: clock, async active-high reset; en_i: sample strobe; sync_i: raw sync level;
// inc_i: count request; edge_o: leading edge this sample; len_ok_o: count == LEN-1;
// cnt_d_o: counter value after this sample
module vga_edge_counter #(
  parameter int W        = 11,
  parameter int LEN      = 800,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic         inc_i,
  output logic         edge_o,
  output logic         len_ok_o,
  output logic [W-1:0] cnt_d_o
);
  logic         prev_q;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    edge_o = en_i && (sync_i == SYNC_POL) && !prev_q;
    cnt_d  = edge_o ? '0 : (en_i && inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  end
  assign len_ok_o = cnt_q == W'(LEN - 1);
  assign cnt_d_o  = cnt_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (en_i) prev_q <= sync_i == SYNC_POL;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: measures VGA line/frame timing, locks after good frames, emits an (x,y,rgb) pixel stream
// Inputs: clk, rst (async active-high), pix_en (pixel strobe), hsync_in, vsync_in, rgb_in (RGB332).
// Outputs: pix_valid/pix_x/pix_y/pix_rgb (1-clk latency pixel stream), frame_start at (0,0),
// locked (timing lock), h_err (bad line or hsync watchdog pulse), v_err (bad frame pulse).
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_valid,
  output logic [XY_W-1:0]  pix_x,
  output logic [XY_W-1:0]  pix_y,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             frame_start,
  output logic             locked,
  output logic             h_err,
  output logic             v_err
);
  localparam logic [H_CNT_W-1:0] H_LO   = H_CNT_W'(H_ACT_START);
  localparam logic [H_CNT_W-1:0] H_HI   = H_CNT_W'(H_ACT_START + H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_WDOG = H_CNT_W'(2 * H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LO   = V_CNT_W'(V_ACT_START);
  localparam logic [V_CNT_W-1:0] V_HI   = V_CNT_W'(V_ACT_START + V_ACTIVE);
  localparam logic [7:0]         GOOD_LOCK = 8'(LOCK_FRAMES);
  state_e               state_q;
  logic                 hs_edge, vs_edge, h_len_ok, v_len_ok;
  logic                 h_seen_q, herr_seen_q;
  logic [7:0]           good_q;
  logic [H_CNT_W-1:0]   h_cnt_d;
  logic [V_CNT_W-1:0]   v_cnt_d;
  logic                 wdog, h_err_d, frame_good, fire;
  logic [XY_W-1:0]      x_d, y_d;
  vga_edge_counter #(.W(H_CNT_W), .LEN(H_TOTAL), .SYNC_POL(SYNC_POL)) u_h (
    .clk(clk), .rst(rst), .en_i(pix_en), .sync_i(hsync_in), .inc_i(1'b1),
    .edge_o(hs_edge), .len_ok_o(h_len_ok), .cnt_d_o(h_cnt_d)
  );
  // lines are counted on hsync edges; a coincident vsync edge clears the count instead
  vga_edge_counter #(.W(V_CNT_W), .LEN(V_TOTAL), .SYNC_POL(SYNC_POL)) u_v (
    .clk(clk), .rst(rst), .en_i(pix_en), .sync_i(vsync_in), .inc_i(hs_edge),
    .edge_o(vs_edge), .len_ok_o(v_len_ok), .cnt_d_o(v_cnt_d)
  );
  always_comb begin
    // h_cnt can only land on the watchdog value by counting up, so this fires once per timeout
    wdog       = pix_en && h_seen_q && h_cnt_d == H_WDOG;
    h_err_d    = (hs_edge && h_seen_q && !h_len_ok) || wdog;
    // an h_err on the closing sample of a frame still spoils that frame
    frame_good = v_len_ok && !herr_seen_q && !h_err_d;
    // window uses post-sample counts so the sync-edge sample itself is position 0
    fire = state_q == LOCKED && pix_en && h_cnt_d >= H_LO && h_cnt_d < H_HI &&
           v_cnt_d >= V_LO && v_cnt_d < V_HI;
    x_d  = XY_W'(h_cnt_d - H_LO);
    y_d  = v_cnt_d - V_LO;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      h_seen_q    <= 1'b0;
      herr_seen_q <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      h_seen_q    <= hs_edge || (h_seen_q && !wdog);
      herr_seen_q <= !vs_edge && (herr_seen_q || h_err_d);
      h_err       <= h_err_d;
      v_err       <= 1'b0;
      pix_valid   <= fire;
      frame_start <= fire && x_d == '0 && y_d == '0;
      if (fire) begin
        pix_x   <= x_d;
        pix_y   <= y_d;
        pix_rgb <= rgb_in;
      end
      case (state_q)
        SEARCH: if (vs_edge) begin
          state_q <= TRACK;
          good_q  <= '0;
        end
        TRACK: if (vs_edge && frame_good && good_q + 8'd1 == GOOD_LOCK) begin
          state_q <= LOCKED;
          locked  <= 1'b1;
          good_q  <= '0;
        end else if (vs_edge && frame_good) begin
          good_q <= good_q + 8'd1;
        end else if (vs_edge || h_err_d) begin
          good_q <= '0;
          v_err  <= vs_edge;
        end
        LOCKED: if ((vs_edge && !frame_good) || h_err_d) begin
          state_q <= SEARCH;
          locked  <= 1'b0;
          good_q  <= '0;
          v_err   <= vs_edge && !frame_good;
        end
        default: begin
          state_q <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
endmodule
